// File: rtl/cp_remover_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cp_remover_param_if                                                      |
// | Sample-stream input and symbol output bundle for cp_remover_param.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cp_remover_param_if #(
  parameter int SAMPLE_W = 16,
  parameter int N_FFT    = 16,
  parameter int CP_MAX   = 8
);
  localparam int CPW   = $clog2(CP_MAX + 1);
  localparam int HALFW = (N_FFT / 2) * SAMPLE_W;

  logic [CPW-1:0]      cp_len;
  logic                in_valid;
  logic                in_sof;
  logic [SAMPLE_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [HALFW-1:0]    out_I;
  logic [HALFW-1:0]    out_Q;
  logic                frame_err;
  logic                overrun;

  modport master (
    output cp_len, in_valid, in_sof, in_data, out_ready,
    input  out_valid, out_I, out_Q, frame_err, overrun
  );

  modport slave (
    input  cp_len, in_valid, in_sof, in_data, out_ready,
    output out_valid, out_I, out_Q, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/cp_remover_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cp_remover_param                                                         |
// | Cyclic-prefix remover: gathers one OFDM symbol, drops a programmable CP. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cp_remover_param #(
  parameter int SAMPLE_W = 16,
  parameter int N_FFT    = 16,
  parameter int CP_MAX   = 8,
  parameter int CP_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  cp_remover_param_if.slave bus
);
  localparam int CPW   = $clog2(CP_MAX + 1);
  localparam int MAXC  = (N_FFT > CP_MAX) ? N_FFT : CP_MAX;
  localparam int CNTW  = $clog2(MAXC + 1);
  localparam int BUFW  = N_FFT * SAMPLE_W;
  localparam int HALFW = BUFW / 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SKIP    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [CPW-1:0]  CP_MAX_C  = CPW'(CP_MAX);
  localparam logic [CNTW-1:0] LAST_DATA = CNTW'(N_FFT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [CPW-1:0]   cp_eff_q, cp_eff_d;
  logic [BUFW-1:0]  buf_q, buf_d;
  logic [HALFW-1:0] out_I_q, out_Q_q;
  logic             out_valid_q, frame_err_q, overrun_q;

  logic             beat, sof, store, complete, accept;
  logic [CPW-1:0]   cp_new;
  logic [CNTW-1:0]  cp_ext;
  logic [CNTW-1:0]  wr_idx;

  assign beat   = bus.in_valid;
  assign sof    = bus.in_valid & bus.in_sof;
  assign cp_new = (bus.cp_len > CP_MAX_C) ? CP_MAX_C : bus.cp_len;
  assign cp_ext = CNTW'(cp_eff_q);
  assign accept = ~out_valid_q | bus.out_ready;

  // A sof beat always restarts framing, whatever state we are in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cp_eff_d = cp_eff_q;
    store    = 1'b0;
    complete = 1'b0;
    wr_idx   = sof ? '0 : cnt_q;
    if (beat) begin
      if (sof) begin
        cp_eff_d = cp_new;
        if ((CP_FIRST != 0) && (cp_new != '0)) begin
          if (cp_new == CPW'(1)) begin
            state_d = CAPTURE;
            cnt_d   = '0;
          end else begin
            state_d = SKIP;
            cnt_d   = CNTW'(1);
          end
        end else begin
          store   = 1'b1;
          state_d = CAPTURE;
          cnt_d   = CNTW'(1);
        end
      end else begin
        case (state_q)
          SKIP: begin
            if ((cnt_q + CNTW'(1)) == cp_ext) begin
              cnt_d = '0;
              if (CP_FIRST != 0) begin
                state_d = CAPTURE;
              end else begin
                state_d  = IDLE;
                complete = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
          CAPTURE: begin
            store = 1'b1;
            if (cnt_q == LAST_DATA) begin
              cnt_d = '0;
              if ((CP_FIRST == 0) && (cp_eff_q != '0)) begin
                state_d = SKIP;
              end else begin
                state_d  = IDLE;
                complete = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Sample k lands at its final packed position so completion is a plain copy.
  always_comb begin
    buf_d = buf_q;
    for (int k = 0; k < N_FFT; k++) begin
      if (store && (wr_idx == CNTW'(k))) begin
        buf_d[(N_FFT - k) * SAMPLE_W - 1 -: SAMPLE_W] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cp_eff_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cp_eff_q <= cp_eff_d;
      buf_q    <= buf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_I_q     <= '0;
      out_Q_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= sof && (state_q != IDLE);
      overrun_q   <= complete && !accept;
      if (complete && accept) begin
        out_valid_q <= 1'b1;
        out_I_q     <= buf_d[BUFW-1 -: HALFW];
        out_Q_q     <= buf_d[HALFW-1:0];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_I     = out_I_q;
  assign bus.out_Q     = out_Q_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_cp_remover_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cp_remover_param                                                      |
// | Drives a leading-CP and a trailing-CP instance from one sample stream.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cp_remover_param;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cp_len;
  logic        in_valid, in_sof, out_ready;
  logic [15:0] in_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  cp_remover_param_if if0 ();
  cp_remover_param_if if1 ();

  assign if0.cp_len = cp_len;   assign if1.cp_len = cp_len;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid;
  assign if0.in_sof = in_sof;   assign if1.in_sof = in_sof;
  assign if0.in_data = in_data; assign if1.in_data = in_data;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;

  cp_remover_param #(.CP_FIRST(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  cp_remover_param #(.CP_FIRST(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  logic [258:0] obs0, obs1;
  assign obs0 = {if0.out_valid, if0.frame_err, if0.overrun, if0.out_I, if0.out_Q};
  assign obs1 = {if1.out_valid, if1.frame_err, if1.overrun, if1.out_I, if1.out_Q};

  // Frame-level reference: a frame is the N_FFT+cp beats following a sof;
  // the symbol is the slice after (leading) or before (trailing) the prefix.
  logic [15:0]  fb [2][48];
  int           fc [2];
  int           fcp [2];
  bit           inf [2];
  logic         ev [2];
  logic         eerr [2];
  logic         eov [2];
  logic [127:0] eI [2];
  logic [127:0] eQ [2];
  logic [15:0]  stim [64];

  function automatic logic [258:0] exp_of(input int d);
    return {ev[d], eerr[d], eov[d], eI[d], eQ[d]};
  endfunction

  function automatic logic [127:0] pack8(input int off);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[(8 - k) * 16 - 1 -: 16] = stim[off + k];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      fc[d] = 0; fcp[d] = 0; inf[d] = 0;
      ev[d] = 0; eerr[d] = 0; eov[d] = 0; eI[d] = '0; eQ[d] = '0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit   done;
      int   off;
      logic nerr, nov;
      done = 0; nerr = 0; nov = 0;
      if (in_valid) begin
        if (in_sof) begin
          nerr   = inf[d];
          inf[d] = 1;
          fc[d]  = 0;
          fcp[d] = (cp_len > 4'd8) ? 8 : int'(cp_len);
        end
        if (inf[d]) begin
          fb[d][fc[d]] = in_data;
          fc[d]++;
          if (fc[d] == 16 + fcp[d]) begin
            done   = 1;
            inf[d] = 0;
          end
        end
      end
      off = (d == 0) ? fcp[d] : 0;
      if (done) begin
        if (!ev[d] || out_ready) begin
          ev[d] = 1;
          for (int k = 0; k < 8; k++) begin
            eI[d][(8 - k) * 16 - 1 -: 16] = fb[d][off + k];
            eQ[d][(8 - k) * 16 - 1 -: 16] = fb[d][off + 8 + k];
          end
        end else begin
          nov = 1;
        end
      end else if (out_ready) begin
        ev[d] = 0;
      end
      eerr[d] = nerr;
      eov[d]  = nov;
    end
  endtask

  task automatic cyc(input bit v, input bit s, input logic [15:0] d, input logic [3:0] c);
    in_valid = v; in_sof = s; in_data = d; cp_len = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    checks++; if (obs0 !== '0) begin failures++; $display("FAIL reset_dut0 got=%h exp=0", obs0); end
    checks++; if (obs1 !== '0) begin failures++; $display("FAIL reset_dut1 got=%h exp=0", obs1); end
    reset = 1'b0;
    cyc(0, 0, 16'h0, 4'd0);
    checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL reset_idle0 got=%h exp=%h", obs0, exp_of(0)); end
  endtask

  task automatic test_cp_first();
    for (int i = 0; i < 19; i++) begin
      cyc(1, i == 0, (i < 3) ? 16'hFFFF : 16'(i - 2), 4'd3);
      checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL cpfirst_model0 beat=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
      checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL cpfirst_model1 beat=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
      if (i == 17) begin
        checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL cpfirst_early got=%b exp=0", if0.out_valid); end
      end
    end
    checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL cpfirst_valid got=%b exp=1", if0.out_valid); end
    checks++; if (if0.out_I !== 128'h0001_0002_0003_0004_0005_0006_0007_0008) begin failures++; $display("FAIL cpfirst_I got=%h", if0.out_I); end
    checks++; if (if0.out_Q !== 128'h0009_000A_000B_000C_000D_000E_000F_0010) begin failures++; $display("FAIL cpfirst_Q got=%h", if0.out_Q); end
    checks++; if (if0.frame_err !== 1'b0) begin failures++; $display("FAIL cpfirst_ferr got=%b exp=0", if0.frame_err); end
    cyc(0, 0, 16'h0, 4'd3);
  endtask

  task automatic test_cp_last();
    for (int i = 0; i < 19; i++) begin
      int gap;
      gap = int'($urandom_range(2));
      for (int g = 0; g < gap; g++) begin
        cyc(0, 1'($urandom), 16'($urandom), 4'($urandom));
        checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL cplast_gap_valid beat=%0d got=%b exp=0", i, if1.out_valid); end
      end
      cyc(1, i == 0, (i < 16) ? 16'(i + 1) : 16'hDEAD, (i == 0) ? 4'd3 : 4'($urandom));
      checks++; if (if1.out_valid !== (i == 18)) begin failures++; $display("FAIL cplast_valid beat=%0d got=%b exp=%b", i, if1.out_valid, i == 18); end
      checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL cplast_model0 beat=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
    end
    checks++; if (if1.out_I !== 128'h0001_0002_0003_0004_0005_0006_0007_0008) begin failures++; $display("FAIL cplast_I got=%h", if1.out_I); end
    checks++; if (if1.out_Q !== 128'h0009_000A_000B_000C_000D_000E_000F_0010) begin failures++; $display("FAIL cplast_Q got=%h", if1.out_Q); end
    cyc(0, 0, 16'h0, 4'd0);
  endtask

  task automatic test_cp_clamp();
    for (int f = 0; f < 2; f++) begin
      int n;
      n = (f == 0) ? 16 : 24;
      for (int i = 0; i < n; i++) begin
        cyc(1, i == 0, 16'($urandom), (i == 0) ? ((f == 0) ? 4'd0 : 4'd12) : 4'($urandom));
        checks++; if (if0.out_valid !== (i == n - 1)) begin failures++; $display("FAIL clamp_valid0 frame=%0d beat=%0d got=%b", f, i, if0.out_valid); end
        checks++; if (if1.out_valid !== (i == n - 1)) begin failures++; $display("FAIL clamp_valid1 frame=%0d beat=%0d got=%b", f, i, if1.out_valid); end
        checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL clamp_model0 beat=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
        checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL clamp_model1 beat=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
      end
    end
    cyc(0, 0, 16'h0, 4'd0);
  endtask

  task automatic test_back_to_back();
    int ov0, ov1;
    ov0 = 0; ov1 = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 36; i++) stim[i] = 16'($urandom);
    for (int i = 0; i < 36; i++) begin
      cyc(1, (i == 0) || (i == 18), stim[i], 4'd2);
      ov0 += int'(if0.overrun);
      ov1 += int'(if1.overrun);
      checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL b2b_model0 beat=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
      checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL b2b_model1 beat=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
    end
    cyc(0, 0, 16'h0, 4'd0);
    checks++; if (ov0 != 1) begin failures++; $display("FAIL b2b_overrun0 got=%0d exp=1", ov0); end
    checks++; if (ov1 != 1) begin failures++; $display("FAIL b2b_overrun1 got=%0d exp=1", ov1); end
    checks++; if ({if0.out_valid, if0.out_I, if0.out_Q} !== {1'b1, pack8(2), pack8(10)}) begin failures++; $display("FAIL b2b_hold0 got=%h", if0.out_I); end
    checks++; if ({if1.out_valid, if1.out_I, if1.out_Q} !== {1'b1, pack8(0), pack8(8)}) begin failures++; $display("FAIL b2b_hold1 got=%h", if1.out_I); end
    out_ready = 1'b1;
    cyc(0, 0, 16'h0, 4'd0);
    checks++; if ({if0.out_valid, if1.out_valid} !== 2'b00) begin failures++; $display("FAIL b2b_drop got=%b%b exp=00", if0.out_valid, if1.out_valid); end
  endtask

  task automatic test_frame_err();
    int fe0, fe1, sy0, sy1;
    fe0 = 0; fe1 = 0; sy0 = 0; sy1 = 0;
    for (int i = 0; i < 27; i++) stim[i] = 16'($urandom);
    for (int i = 0; i < 29; i++) begin
      if (i < 27) cyc(1, (i == 0) || (i == 8), stim[i], 4'd3);
      else        cyc(0, 0, 16'h0, 4'd3);
      fe0 += int'(if0.frame_err); fe1 += int'(if1.frame_err);
      sy0 += int'(if0.out_valid); sy1 += int'(if1.out_valid);
      checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL ferr_model0 beat=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
      checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL ferr_model1 beat=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
      if (i == 26) begin
        checks++; if ({if0.out_I, if0.out_Q} !== {pack8(11), pack8(19)}) begin failures++; $display("FAIL ferr_data0 got=%h", if0.out_I); end
      end
    end
    checks++; if (fe0 != 1 || fe1 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d/%0d exp=1/1", fe0, fe1); end
    checks++; if (sy0 != 1 || sy1 != 1) begin failures++; $display("FAIL ferr_symbols got=%0d/%0d exp=1/1", sy0, sy1); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) cyc(1, i == 0, 16'($urandom), 4'd1);
    reset = 1'b1;
    #1;
    checks++; if ({obs0, obs1} !== '0) begin failures++; $display("FAIL rstmid_async got=%h/%h exp=0", obs0, obs1); end
    model_reset();
    @(negedge clk);
    checks++; if ({obs0, obs1} !== '0) begin failures++; $display("FAIL rstmid_hold got=%h/%h exp=0", obs0, obs1); end
    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) begin
        stim[i] = 16'($urandom);
        cyc(1, i == 0, stim[i], 4'd1);
      end else begin
        cyc(0, 0, 16'h0, 4'd1);
      end
      checks++; if (if0.out_valid !== (i == 16)) begin failures++; $display("FAIL rstmid_valid beat=%0d got=%b", i, if0.out_valid); end
      checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL rstmid_model1 beat=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
      if (i == 16) begin
        checks++; if ({if0.out_I, if0.out_Q} !== {pack8(1), pack8(9)}) begin failures++; $display("FAIL rstmid_data got=%h", if0.out_I); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(3) != 0);
      cyc($urandom_range(3) != 0, $urandom_range(24) == 0, 16'($urandom), 4'($urandom));
      checks++; if (obs0 !== exp_of(0)) begin failures++; $display("FAIL random_model0 cyc=%0d got=%h exp=%h", i, obs0, exp_of(0)); end
      checks++; if (obs1 !== exp_of(1)) begin failures++; $display("FAIL random_model1 cyc=%0d got=%h exp=%h", i, obs1, exp_of(1)); end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; cp_len = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_cp_first();
    test_cp_last();
    test_cp_clamp();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cp_remover_param.md
Name: cp_remover_param

Overview:
- Parametrised cyclic-prefix remover for the OFDM receive path; sits between the deserialiser stream and the FFT/demapper.
- Collects one symbol of N_FFT samples, discards a runtime-programmable cyclic prefix, and presents the symbol as two packed halves (out_I, out_Q).
- Supports leading-CP (standard) and trailing-CP (legacy frame format) ordering.
- Adds frame sync, error detection and an output valid/ready handshake.

Parameters:
- SAMPLE_W, 16, bits per input sample.
- N_FFT, 16, useful samples per symbol; even, at least 2.
- CP_MAX, 8, largest supported prefix length, at least 1.
- CP_FIRST, 1: 1 = prefix precedes the useful data; 0 = prefix trails the useful data.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cp_len  in  $clog2(CP_MAX+1)  prefix length; sampled only at the sof beat.
- in_valid  in  1  input sample valid.
- in_sof  in  1  start-of-frame; qualified by in_valid.
- in_data  in  SAMPLE_W  input sample.
- out_valid  out  1  symbol available.
- out_ready  in  1  downstream accepts the symbol.
- out_I  out  N_FFT/2*SAMPLE_W  samples 0..N_FFT/2-1; sample 0 in the MSBs.
- out_Q  out  N_FFT/2*SAMPLE_W  samples N_FFT/2..N_FFT-1; sample N_FFT/2 in the MSBs.
- frame_err  out  1  one-cycle pulse on a sof arriving mid-frame.
- overrun  out  1  one-cycle pulse when a completed symbol is dropped.

Behaviour:
- Reset is asynchronous and active-high, on clock clk.
  - Clears out_I, out_Q, out_valid, frame_err, overrun, all counters and the sample buffer.
  - FSM returns to IDLE.
  - Reset mid-frame discards the partial symbol; no output is produced for it.
- Beat: a cycle with in_valid=1. Cycles with in_valid=0 hold all state.
- Each sof beat latches cp_eff = min(cp_len, CP_MAX). Changes to cp_len mid-frame are ignored.
- FSM states are IDLE, SKIP and CAPTURE.
  - IDLE: non-sof beats are discarded.
- Transitions with CP_FIRST=1:
  - sof beat, cp_eff>0: the beat is CP sample 0; go to SKIP.
  - sof beat, cp_eff=0: the beat is data sample 0; go to CAPTURE.
  - SKIP: counts cp_eff beats including the sof beat, then goes to CAPTURE.
  - CAPTURE: stores N_FFT beats, then goes to IDLE.
- Transitions with CP_FIRST=0:
  - sof beat: the beat is data sample 0; go to CAPTURE.
  - CAPTURE: after N_FFT beats, go to SKIP if cp_eff>0, else IDLE.
  - SKIP: after cp_eff beats, go to IDLE.
- Back-to-back frames: a sof beat in the cycle immediately after the final beat of a frame is accepted normally; no gap is required.
- Sample storage: sample k is written to the buffer at its packed position.
  - k < N_FFT/2: out_I slice [(N_FFT/2-k)*SAMPLE_W-1 -: SAMPLE_W].
  - Otherwise: out_Q slice at index k-N_FFT/2, same formula.
- Completion: the final beat of the frame is the last CAPTURE beat (CP_FIRST=1) or the last SKIP beat (CP_FIRST=0, cp_eff>0).
  - If out_valid=0, or out_valid=1 and out_ready=1, in that cycle: the buffer is copied to out_I/out_Q and out_valid=1 on the next cycle.
  - Latency: 1 cycle from the final beat.
  - Otherwise the symbol is dropped, overrun pulses the next cycle, and out_I/out_Q are unchanged.
- Handshake:
  - out_valid stays high and out_I/out_Q stay stable until a cycle with out_ready=1.
  - out_valid falls next cycle unless a new symbol completes in that same cycle, in which case out_valid stays high with the new data.
- Mid-frame sof (state SKIP or CAPTURE):
  - frame_err pulses the next cycle.
  - The partial symbol is discarded.
  - The sof beat starts a new frame with a freshly latched cp_len.
- in_sof with in_valid=0 is ignored.

Test Plan:
- Defaults, cp_len=3, one frame: 3 CP beats 0xFFFF, then 16 data beats 0x0001..0x0010.
  - out_valid rises 1 cycle after beat 19.
  - out_I = {0x0001..0x0008}, out_Q = {0x0009..0x0010}.
  - frame_err=0.
- CP_FIRST=0, cp_len=3: 16 data beats, then 3 junk beats 0xDEAD, with in_valid gaps between beats.
  - Same out_I/out_Q as the first scenario; junk never appears.
  - out_valid only 1 cycle after the 19th valid beat.
- cp_len=0, then cp_len=12 (clamped to 8):
  - First frame completes after 16 beats; second after 24 beats.
  - Changing cp_len mid-frame has no effect.
- out_ready=0 held while two frames complete:
  - First symbol is held stable; overrun pulses once for the second.
  - After out_ready=1 for 1 cycle, out_valid drops.
- sof asserted at data beat 5, followed by a full clean frame:
  - frame_err pulses once.
  - Exactly one symbol is output, and it is the clean frame's data.
- reset asserted mid-CAPTURE, then a full frame:
  - All outputs are 0 during reset; no stale symbol appears.
  - The next frame outputs correctly.
